// File: rtl/tx_ts_stamper.sv
// ============================================================================
// Module   : tx_ts_stamper
// Brief    : Transmit-path stage that stamps (or converts to elapsed time) one
//            packet word with a free-running timestamp captured at SOP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_ts_stamper #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int TS_WIDTH   = 64,
    parameter int TS_WORD    = 1,
    parameter int MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  stamp_en,
    input  logic                  ts_clear,
    output logic [TS_WIDTH-1:0]   ts_now,
    output logic [31:0]           pkts_stamped,
    output logic [31:0]           pkts_short
);

    localparam int IDX_W = $clog2(TS_WORD + 2);
    localparam logic [IDX_W-1:0] c_IDX_TGT = IDX_W'(TS_WORD);
    localparam logic [IDX_W-1:0] c_IDX_MAX = IDX_W'(TS_WORD + 1);

    localparam logic [0:0] c_S_HDR  = 1'b0;
    localparam logic [0:0] c_S_DATA = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [TS_WIDTH-1:0]   r_ts_cap;
    logic                  r_armed;
    logic [IDX_W-1:0]      r_word_idx;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic                  r_out_wr;
    logic [31:0]           r_pkts_stamped;
    logic [31:0]           r_pkts_short;

    logic                  w_ctrl_zero;
    logic                  w_sop;
    logic                  w_eop;
    logic                  w_data_word;
    logic [IDX_W-1:0]      w_idx_cur;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_armed_cur;
    logic [TS_WIDTH-1:0]   w_cap_cur;
    logic                  w_target;
    logic                  w_short;
    logic [TS_WIDTH-1:0]   w_field;
    logic [DATA_WIDTH-1:0] w_out_data;

    assign w_ctrl_zero = (in_ctrl == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (in_wr) begin
            case (r_state)
                c_S_HDR:  if (w_ctrl_zero)  w_state_nxt = c_S_DATA;
                c_S_DATA: if (!w_ctrl_zero) w_state_nxt = c_S_HDR;
                default:  w_state_nxt = c_S_HDR;
            endcase
        end
    end

    // ---------------- FSM: decoded outputs ----------------
    always_comb begin
        w_sop       = in_wr && (r_state == c_S_HDR) && w_ctrl_zero;
        w_eop       = in_wr && (r_state == c_S_DATA) && !w_ctrl_zero;
        w_data_word = w_sop || (in_wr && (r_state == c_S_DATA));
    end

    // The SOP word uses the context it establishes, so TS_WORD=0 works in-cycle.
    // r_word_idx holds the index of the next data word to arrive.
    always_comb begin
        w_idx_cur   = w_sop ? '0 : r_word_idx;
        w_armed_cur = w_sop ? stamp_en : r_armed;
        w_cap_cur   = w_sop ? r_ts : r_ts_cap;
        w_idx_nxt   = (w_idx_cur == c_IDX_MAX) ? c_IDX_MAX : w_idx_cur + 1'b1;
        w_target    = w_data_word && w_armed_cur && (w_idx_cur == c_IDX_TGT);
        w_short     = w_eop && r_armed && (r_word_idx < c_IDX_TGT);
    end

    always_comb begin
        if (MODE == 1) begin
            w_field = w_cap_cur - in_data[TS_WIDTH-1:0];
        end else begin
            w_field = w_cap_cur;
        end
        w_out_data = in_data;
        if (w_target) begin
            w_out_data[TS_WIDTH-1:0] = w_field;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else if (ts_clear) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts_cap   <= '0;
            r_armed    <= 1'b0;
            r_word_idx <= '0;
        end else if (w_sop) begin
            r_ts_cap   <= r_ts;
            r_armed    <= stamp_en;
            r_word_idx <= w_idx_nxt;
        end else if (w_data_word) begin
            r_word_idx <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data     <= '0;
            r_out_ctrl     <= '0;
            r_out_wr       <= 1'b0;
            r_pkts_stamped <= '0;
            r_pkts_short   <= '0;
        end else begin
            r_out_data <= w_out_data;
            r_out_ctrl <= in_ctrl;
            r_out_wr   <= in_wr;
            if (w_target) r_pkts_stamped <= r_pkts_stamped + 32'd1;
            if (w_short)  r_pkts_short   <= r_pkts_short + 32'd1;
        end
    end

    assign in_rdy       = out_rdy;
    assign out_data     = r_out_data;
    assign out_ctrl     = r_out_ctrl;
    assign out_wr       = r_out_wr;
    assign ts_now       = r_ts;
    assign pkts_stamped = r_pkts_stamped;
    assign pkts_short   = r_pkts_short;

endmodule

`default_nettype wire

// File: tb/tb_tx_ts_stamper.sv
// ============================================================================
// Module   : tb_tx_ts_stamper
// Brief    : Self-checking bench for tx_ts_stamper (three parameterisations
//            sharing one input stream).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tx_ts_stamper;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        out_rdy;
    logic        stamp_en;
    logic        ts_clear;

    logic        in_rdy0, in_rdy1, in_rdy2;
    logic [63:0] out_data0, out_data1, out_data2;
    logic [7:0]  out_ctrl0, out_ctrl1, out_ctrl2;
    logic        out_wr0, out_wr1, out_wr2;
    logic [63:0] ts_now0, ts_now1;
    logic [7:0]  ts_now2;
    logic [31:0] stamped0, stamped1, stamped2;
    logic [31:0] short0, short1, short2;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_ts = '0;

    always #5 clk = ~clk;

    tx_ts_stamper #(.DATA_WIDTH(64), .TS_WIDTH(64), .TS_WORD(1), .MODE(0)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .in_rdy(in_rdy0), .out_data(out_data0), .out_ctrl(out_ctrl0), .out_wr(out_wr0),
        .out_rdy(out_rdy), .stamp_en(stamp_en), .ts_clear(ts_clear), .ts_now(ts_now0),
        .pkts_stamped(stamped0), .pkts_short(short0));

    tx_ts_stamper #(.DATA_WIDTH(64), .TS_WIDTH(64), .TS_WORD(2), .MODE(1)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .in_rdy(in_rdy1), .out_data(out_data1), .out_ctrl(out_ctrl1), .out_wr(out_wr1),
        .out_rdy(out_rdy), .stamp_en(stamp_en), .ts_clear(ts_clear), .ts_now(ts_now1),
        .pkts_stamped(stamped1), .pkts_short(short1));

    tx_ts_stamper #(.DATA_WIDTH(64), .TS_WIDTH(8), .TS_WORD(3), .MODE(0)) u2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .in_rdy(in_rdy2), .out_data(out_data2), .out_ctrl(out_ctrl2), .out_wr(out_wr2),
        .out_rdy(out_rdy), .stamp_en(stamp_en), .ts_clear(ts_clear), .ts_now(ts_now2),
        .pkts_stamped(stamped2), .pkts_short(short2));

    typedef struct {
        int          pre;
        bit          clr;
        bit          en;
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock edge with the given word; returns 1 time unit after the edge.
    task automatic step(input logic wr, input logic [63:0] d, input logic [7:0] c);
        in_wr   = wr;
        in_data = d;
        in_ctrl = c;
        @(posedge clk);
        m_ts = (reset || ts_clear) ? 64'd0 : m_ts + 64'd1;
        #1;
    endtask

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            ts_clear = clr && (i == 0);
            step(1'b0, 64'h0, 8'h0);
        end
        ts_clear = 1'b0;
        chk("idle_out_wr", out_wr0, 1'b0);
    endtask

    task automatic add(input int pre, input bit clr, input bit en, input logic [7:0] c,
                       input logic [63:0] d, input logic [63:0] e0, input logic [63:0] e1,
                       input logic [63:0] e2);
        vec_t v;
        v.pre = pre; v.clr = clr; v.en = en; v.ctrl = c; v.data = d;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        vt.push_back(v);
    endtask

    task automatic pass(input int pre, input bit clr, input bit en, input logic [7:0] c,
                        input logic [63:0] d);
        add(pre, clr, en, c, d, d, d, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] da;
        logic [63:0] d;
        logic [63:0] cap;
        logic [63:0] exp;
        logic [7:0]  c;
        int          p;
        int          w;
        int          seen;

        da = 64'hC0DE_0000_0000_00A0;

        // Packet A: SOP at ts=100
        pass(99, 1, 1, 8'hFF, 64'h1111);
        pass(0, 0, 1, 8'h01, 64'h2222);
        pass(0, 0, 1, 8'h00, da);
        add (0, 0, 1, 8'h00, da + 1, 64'd100, da + 1, da + 1);
        add (0, 0, 1, 8'h00, da + 2, da + 2, 64'h3F21_FFFF_FFFF_FFC2, da + 2);
        add (0, 0, 1, 8'h00, da + 3, da + 3, da + 3, 64'hC0DE_0000_0000_0064);
        pass(0, 0, 1, 8'h00, da + 4);
        pass(0, 0, 1, 8'h00, da + 5);
        pass(0, 0, 1, 8'h80, 64'hEE);
        // Packet B: SOP at ts=250, elapsed field 40
        pass(249, 1, 1, 8'hFF, 64'h1111);
        pass(0, 0, 1, 8'h01, 64'h2222);
        pass(0, 0, 1, 8'h00, 64'h10);
        add (0, 0, 1, 8'h00, 64'h11, 64'd250, 64'h11, 64'h11);
        add (0, 0, 1, 8'h00, 64'd40, 64'd40, 64'd210, 64'd40);
        add (0, 0, 1, 8'h80, 64'h55, 64'h55, 64'h55, 64'hFA);
        // Packet C: elapsed result goes negative
        pass(249, 1, 1, 8'hFF, 64'h1111);
        pass(0, 0, 1, 8'h01, 64'h2222);
        pass(0, 0, 1, 8'h00, 64'h10);
        add (0, 0, 1, 8'h00, 64'h11, 64'd250, 64'h11, 64'h11);
        add (0, 0, 1, 8'h00, 64'd300, 64'd300, 64'hFFFF_FFFF_FFFF_FFCE, 64'd300);
        add (0, 0, 1, 8'h80, 64'h55, 64'h55, 64'h55, 64'hFA);
        // Packet D: two data words; short for TS_WORD 2 and 3
        pass(10, 1, 1, 8'hFF, 64'h1111);
        pass(0, 0, 1, 8'h01, 64'h2222);
        pass(0, 0, 1, 8'h00, 64'h30);
        add (0, 0, 1, 8'h80, 64'h31, 64'd11, 64'h31, 64'h31);
        // Packet E: disarmed at SOP, stamp_en rises mid-packet
        pass(0, 0, 0, 8'hFF, 64'h1111);
        pass(0, 0, 0, 8'h01, 64'h2222);
        pass(0, 0, 0, 8'h00, 64'h40);
        pass(0, 0, 1, 8'h00, 64'h41);
        pass(0, 0, 1, 8'h00, 64'h42);
        pass(0, 0, 1, 8'h00, 64'h43);
        pass(0, 0, 1, 8'h80, 64'h44);

        reset = 1'b1; stamp_en = 1'b1; ts_clear = 1'b0; out_rdy = 1'b1;
        step(1'b1, 64'hDEAD, 8'h00);
        step(1'b1, 64'hDEAD, 8'h00);
        chk("rst_out_wr", out_wr0, 1'b0);
        chk("rst_out_data", out_data0, 64'h0);
        chk("rst_out_ctrl", out_ctrl0, 8'h0);
        chk("rst_ts_now", ts_now0, 64'h0);
        chk("rst_stamped", stamped0, 32'h0);
        chk("rst_short", short0, 32'h0);
        reset = 1'b0;

        foreach (vt[i]) begin
            if (vt[i].pre > 0) idle(vt[i].pre, vt[i].clr);
            stamp_en = vt[i].en;
            step(1'b1, vt[i].data, vt[i].ctrl);
            chk($sformatf("vec%0d_wr", i), {out_wr2, out_wr1, out_wr0}, 3'b111);
            chk($sformatf("vec%0d_ctrl", i), out_ctrl0, vt[i].ctrl);
            chk($sformatf("vec%0d_d0", i), out_data0, vt[i].e0);
            chk($sformatf("vec%0d_d1", i), out_data1, vt[i].e1);
            chk($sformatf("vec%0d_d2", i), out_data2, vt[i].e2);
        end
        stamp_en = 1'b1;
        chk("tbl_stamped0", stamped0, 32'd4);
        chk("tbl_short0", short0, 32'd0);
        chk("tbl_stamped1", stamped1, 32'd3);
        chk("tbl_short1", short1, 32'd1);
        chk("tbl_stamped2", stamped2, 32'd3);
        chk("tbl_short2", short2, 32'd1);

        // ts_clear coincident with SOP at ts=77
        idle(76, 1);
        step(1'b1, 64'h1111, 8'hFF);
        step(1'b1, 64'h2222, 8'h01);
        ts_clear = 1'b1;
        step(1'b1, 64'h50, 8'h00);
        ts_clear = 1'b0;
        chk("clr_sop_ts_now", ts_now0, 64'd0);
        step(1'b1, 64'h51, 8'h00);
        chk("clr_sop_stamp0", out_data0, 64'd77);
        step(1'b1, 64'h4D, 8'h80);
        chk("clr_sop_elapsed1", out_data1, 64'd0);
        chk("clr_sop_short_data2", out_data2, 64'h4D);
        chk("clr_stamped0", stamped0, 32'd5);
        chk("clr_stamped1", stamped1, 32'd4);
        chk("clr_short2", short2, 32'd2);

        // 8-bit counter wrap
        idle(256, 1);
        chk("wrap_ts8_255", ts_now2, 8'd255);
        idle(1, 0);
        chk("wrap_ts8_0", ts_now2, 8'd0);
        chk("wrap_ts64_256", ts_now0, 64'd256);

        // Reset in the middle of an armed packet
        step(1'b1, 64'h1111, 8'hFF);
        step(1'b1, 64'h2222, 8'h01);
        step(1'b1, 64'h60, 8'h00);
        reset = 1'b1;
        step(1'b1, 64'h61, 8'h00);
        reset = 1'b0;
        chk("midrst_out_wr", out_wr2, 1'b0);
        chk("midrst_out_data", out_data2, 64'h0);
        chk("midrst_out_ctrl", out_ctrl2, 8'h0);
        chk("midrst_stamped", stamped2, 32'd0);
        step(1'b1, 64'h1111, 8'hFF);
        step(1'b1, 64'h2222, 8'h01);
        step(1'b1, 64'h70, 8'h00);
        step(1'b1, 64'h71, 8'h00);
        chk("midrst_stamp0", out_data0, 64'd2);
        step(1'b1, 64'h72, 8'h00);
        step(1'b1, 64'hFFFF_0000_0000_0063, 8'h00);
        chk("midrst_stamp2", out_data2, 64'hFFFF_0000_0000_0002);
        step(1'b1, 64'h74, 8'h80);
        chk("midrst_short2", short2, 32'd0);
        chk("midrst_stamped2", stamped2, 32'd1);

        // Backpressure: out_rdy toggles every 3 cycles, 20 packets back to back
        reset = 1'b1;
        step(1'b0, 64'h0, 8'h0);
        reset = 1'b0;
        p = 0; w = 0; seen = 0; cap = '0;
        for (int k = 0; k < 2000 && p < 20; k++) begin
            out_rdy = ((k / 3) % 2 == 0);
            #1;
            chk("bp_in_rdy", in_rdy0, out_rdy);
            if (in_rdy0) begin
                d   = 64'hABCD_0000_0000_0000 | 64'(p * 16 + w);
                c   = (w == 0) ? 8'hFF : ((w == 4) ? 8'h80 : 8'h00);
                if (w == 1) cap = m_ts;
                exp = (w == 2) ? cap : d;
                step(1'b1, d, c);
                chk("bp_out_wr", out_wr0, 1'b1);
                chk("bp_out_data", out_data0, exp);
                chk("bp_out_ctrl", out_ctrl0, c);
                if (out_wr0) seen++;
                w++;
                if (w == 5) begin
                    w = 0;
                    p++;
                end
            end else begin
                step(1'b0, 64'h0, 8'h0);
                chk("bp_idle_wr", out_wr0, 1'b0);
            end
        end
        out_rdy = 1'b1;
        chk("bp_all_sent", p, 20);
        chk("bp_words_seen", seen, 100);
        chk("bp_stamped", stamped0, 32'd20);
        chk("bp_ts_now", ts_now0, m_ts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tx_ts_stamper.md
Name: tx_ts_stamper

Overview:
- Parametrised datapath stage for the rtt_probe transmit path. It sits between the output port lookup and the MAC group TX queue.
- Contains its own free-running timestamp counter of width TS_WIDTH.
- Captures the counter value when a packet's first data word is accepted.
- Either overwrites a chosen packet word with the captured value, or replaces that word with the elapsed time (captured value minus the word's contents) for echo/RTT computation.
- Keeps per-block counters of stamped packets and of packets too short to stamp.

Parameters:
- DATA_WIDTH, 64, datapath word width in bits.
- CTRL_WIDTH, DATA_WIDTH/8, control width in bits.
- TS_WIDTH, 64, timestamp width in bits. Must satisfy 1 <= TS_WIDTH <= DATA_WIDTH.
- TS_WORD, 1, index of the target word, counted from 0 at the first data word.
- MODE, 0, 0 = overwrite, 1 = elapsed (field := captured - field).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_WIDTH  input word.
- in_ctrl  in  CTRL_WIDTH  input control. Nonzero before data = module header word; zero = data word; nonzero after data = last word.
- in_wr  in  1  input word valid.
- in_rdy  out  1  upstream may write.
- out_data  out  DATA_WIDTH  output word.
- out_ctrl  out  CTRL_WIDTH  output control.
- out_wr  out  1  output word valid.
- out_rdy  in  1  downstream may accept.
- stamp_en  in  1  enables stamping; sampled at start of packet.
- ts_clear  in  1  synchronous clear of the timestamp counter.
- ts_now  out  TS_WIDTH  current counter value.
- pkts_stamped  out  32  count of packets stamped.
- pkts_short  out  32  count of packets that ended before TS_WORD with stamping armed.

Behaviour:
- Timestamp counter:
  - Increments by 1 every clk and wraps modulo 2^TS_WIDTH.
  - When ts_clear=1, the next value is 0.
  - Reset value is 0.
  - ts_now is the register output.
- Handshake:
  - in_rdy = out_rdy (combinational passthrough).
  - Upstream writes only when in_rdy is high.
  - Fixed latency of exactly 1 cycle: out_data/out_ctrl/out_wr are registered copies of in_data/in_ctrl/in_wr, except for the modification to the target word.
  - When in_wr=0, out_wr=0 on the next cycle.
- State machine (advances only on in_wr=1):
  - HDR: in_ctrl!=0 → stay in HDR, pass the word. in_ctrl==0 → this is SOP:
    - capture ts_now into ts_cap (the pre-clear value, even if ts_clear=1 in the same cycle);
    - latch armed = stamp_en;
    - set word_idx = 0 for this word;
    - go to DATA.
  - DATA: each accepted word increments word_idx. The word whose index equals TS_WORD is the target.
    - A nonzero in_ctrl word is EOP and returns the FSM to HDR.
    - EOP counts as a data word with its own index.
  - word_idx saturates at TS_WORD+1. It never wraps, so long packets are never stamped twice.
- Target word modification (only when armed=1 and index==TS_WORD):
  - MODE 0: out_data[TS_WIDTH-1:0] = ts_cap.
  - MODE 1: out_data[TS_WIDTH-1:0] = (ts_cap - in_data[TS_WIDTH-1:0]) mod 2^TS_WIDTH.
  - out_data[DATA_WIDTH-1:TS_WIDTH] and out_ctrl are unchanged.
  - If TS_WORD=0, the SOP word itself is the target, using the ts_cap value captured in that same cycle.
  - pkts_stamped increments by 1 on the cycle the target word is accepted.
- Short packets: if EOP is accepted with armed=1 and index < TS_WORD, pkts_short increments by 1 and no word is modified.
- Counters:
  - Both 32 bits, wrap at 2^32.
  - Both are 0 on reset.
  - The armed=0 case increments neither counter.
- Reset:
  - out_wr=0, out_data=0, out_ctrl=0.
  - FSM in HDR, armed=0, word_idx=0, ts_cap=0.
  - Reset mid-packet discards the remainder of that packet's stamping context. Following words are treated as a new packet from HDR.
- stamp_en changes mid-packet have no effect until the next SOP.

Test Plan:
1. Reset, then 2 header words, 6 data words, EOP ctrl=0x80; MODE 0, TS_WORD=1, stamp_en=1; SOP accepted when ts_now=100 → output data word 1 low 64 bits = 100, all other words bit-exact, latency 1, pkts_stamped=1.
2. MODE 1, TS_WORD=2, input word 2 = 40, SOP at ts_now=250 → word 2 out = 210. Input field = 300, SOP at 250 → output = 2^64-50.
3. Same packet with stamp_en=1 but only 2 words total (EOP at index 1), TS_WORD=2 → no modification, pkts_short=1, pkts_stamped unchanged. With stamp_en=0 → both counters unchanged.
4. out_rdy toggled 1/0 every 3 cycles, upstream honouring in_rdy, 20 back-to-back packets → each stamped value equals ts_now at its SOP accept cycle, pkts_stamped=20, no dropped or duplicated words.
5. ts_clear asserted in the SOP cycle at ts_now=77 → stamped value 77, ts_now=0 on the next cycle. Counter wrap (TS_WIDTH=8) from 255 → 0.
6. reset pulsed at data word 1 of an armed packet (TS_WORD=3) → outputs 0 the next cycle. The next packet is stamped at its own TS_WORD, pkts_short=0.
